// File: rtl/pe_pkg.sv
// pe_pkg -- definitions shared by the processing-element controller and the
// processing element datapath.
//   PE_N       : register-file entries per bank (A, B and C)
//   PE_ADDR_W  : index width into a bank, clog2(PE_N)
//   pe_op_e    : command opcodes carried on OPCODE
//   pe_state_e : controller FSM states
//   BANK_C     : INOUT_MUX code selecting the result bank
package pe_pkg;

  localparam int PE_N      = 16;
  localparam int PE_ADDR_W = 4;

  typedef enum logic [1:0] {
    OP_LOAD_A  = 2'd0,
    OP_LOAD_B  = 2'd1,
    OP_MAC     = 2'd2,
    OP_STORE_C = 2'd3
  } pe_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_MAC   = 3'd2,
    ST_WB    = 3'd3,
    ST_STORE = 3'd4,
    ST_FIN   = 3'd5
  } pe_state_e;

  // Bank codes on INOUT_MUX. LOAD reuses the opcode directly (A=0, B=1),
  // so only the result bank needs its own name.
  localparam logic [1:0] BANK_C = 2'd2;

endpackage

// File: rtl/pe_index_counter.sv
// pe_index_counter -- element index for LOAD / MAC / STORE sequencing.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset, idx -> 0
//   clr   : synchronous clear, idx -> 0 (held while the controller is idle)
//   inc   : advance idx by one
//   len   : element count of the current command (already clamped to N)
//   idx   : current element index
//   last  : idx is the terminal element, idx == len-1
module pe_index_counter
  import pe_pkg::*;
#(
  parameter int ADDR_W = PE_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  input  logic [ADDR_W:0]   len,
  output logic [ADDR_W-1:0] idx,
  output logic              last
);

  logic [ADDR_W-1:0] idx_q, idx_d;

  // For len == 0 the subtraction wraps to all ones, which idx can never
  // reach; the controller never relies on last in that case anyway.
  assign last = ({1'b0, idx_q} == (len - (ADDR_W+1)'(1)));
  assign idx  = idx_q;

  // The terminal element never increments, so idx stays within 0..len-1
  // and never wraps even when len == N.
  always_comb begin
    idx_d = idx_q;
    if (clr) begin
      idx_d = '0;
    end else if (inc && !last) begin
      idx_d = idx_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/pe_controller.sv
// pe_controller -- command sequencer for one processing element.
// Accepts LOAD_A / LOAD_B / MAC / STORE_C commands in IDLE and steers the
// register-file and ALU muxes element by element.
//   CLK, RSTN      : clock; synchronous active-high reset (RSTN=1 resets)
//   START          : command strobe, only looked at in IDLE
//   OPCODE/LEN/DEST: command fields captured on START
//   IN_VALID/IN_READY   : load data handshake (LOAD)
//   OUT_VALID/OUT_READY : result data handshake (STORE)
//   INOUT_MUX      : bank select 0=A 1=B 2=C
//   INDATA_MUX     : A/B bank index
//   OUTDATA_MUX    : C bank index
//   WRITE_EN       : register-file write strobe
//   ALUREG_MUX     : ALU operands from REG_A/REG_B
//   ALUACC_MUX     : 0 restart accumulation, 1 accumulate
//   BUSY, DONE     : command in progress, one-cycle completion pulse
//
// Handshakes: a transfer happens in a cycle where both valid and ready are
// high at the rising edge; IN_READY is a pure function of state (no path
// from IN_VALID), WRITE_EN follows IN_VALID combinationally in that cycle,
// and OUT_VALID/OUTDATA_MUX stay stable until OUT_READY is seen.
module pe_controller
  import pe_pkg::*;
#(
  parameter int N      = PE_N,
  parameter int ADDR_W = PE_ADDR_W
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              START,
  input  logic [1:0]        OPCODE,
  input  logic [ADDR_W:0]   LEN,
  input  logic [ADDR_W-1:0] DEST,
  input  logic              IN_VALID,
  output logic              IN_READY,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [1:0]        INOUT_MUX,
  output logic [ADDR_W-1:0] INDATA_MUX,
  output logic [ADDR_W-1:0] OUTDATA_MUX,
  output logic              WRITE_EN,
  output logic              ALUREG_MUX,
  output logic              ALUACC_MUX,
  output logic              BUSY,
  output logic              DONE
);

  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(N);

  pe_state_e         state_q, state_d;
  pe_op_e            op_q, op_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W-1:0] dest_q, dest_d;

  logic              cnt_clr;
  logic              cnt_inc;
  logic [ADDR_W-1:0] idx;
  logic              idx_last;
  logic              len_zero;

  assign len_zero = (len_q == '0);
  assign BUSY     = (state_q != ST_IDLE);

  pe_index_counter #(
    .ADDR_W (ADDR_W)
  ) u_idx (
    .clk  (CLK),
    .rst  (RSTN),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .len  (len_q),
    .idx  (idx),
    .last (idx_last)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    len_d       = len_q;
    dest_d      = dest_q;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    IN_READY    = 1'b0;
    OUT_VALID   = 1'b0;
    INOUT_MUX   = 2'd0;
    INDATA_MUX  = '0;
    OUTDATA_MUX = '0;
    WRITE_EN    = 1'b0;
    ALUREG_MUX  = 1'b0;
    ALUACC_MUX  = 1'b0;
    DONE        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Holding the counter clear here makes every LOAD/MAC/STORE start
        // at element 0.
        cnt_clr = 1'b1;
        if (START) begin
          op_d   = pe_op_e'(OPCODE);
          len_d  = (LEN > LEN_MAX) ? LEN_MAX : LEN;
          dest_d = DEST;
          unique case (pe_op_e'(OPCODE))
            OP_LOAD_A, OP_LOAD_B: state_d = ST_LOAD;
            OP_MAC:               state_d = ST_MAC;
            default:              state_d = ST_STORE;
          endcase
        end
      end

      // A zero-length command spends its one working cycle with every
      // strobe low and goes straight to FIN (no WB, no transfers), so its
      // START-to-DONE latency is LEN+2 like a MAC.
      ST_LOAD: begin
        if (len_zero) begin
          state_d = ST_FIN;
        end else begin
          IN_READY   = 1'b1;
          INOUT_MUX  = op_q;
          INDATA_MUX = idx;
          WRITE_EN   = IN_VALID;
          cnt_inc    = IN_VALID;
          if (IN_VALID && idx_last) begin
            state_d = ST_FIN;
          end
        end
      end

      ST_MAC: begin
        if (len_zero) begin
          state_d = ST_FIN;
        end else begin
          INDATA_MUX = idx;
          ALUREG_MUX = 1'b1;
          ALUACC_MUX = (idx != '0);
          cnt_inc    = 1'b1;
          if (idx_last) begin
            state_d = ST_WB;
          end
        end
      end

      ST_WB: begin
        INOUT_MUX   = BANK_C;
        OUTDATA_MUX = dest_q;
        WRITE_EN    = 1'b1;
        state_d     = ST_FIN;
      end

      ST_STORE: begin
        if (len_zero) begin
          state_d = ST_FIN;
        end else begin
          OUT_VALID   = 1'b1;
          OUTDATA_MUX = idx;
          cnt_inc     = OUT_READY;
          if (OUT_READY && idx_last) begin
            state_d = ST_FIN;
          end
        end
      end

      ST_FIN: begin
        // START is deliberately not looked at here; a held START only
        // launches a new command once it is seen again in IDLE.
        DONE    = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RSTN) begin
      state_q <= ST_IDLE;
      op_q    <= OP_LOAD_A;
      len_q   <= '0;
      dest_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      len_q   <= len_d;
      dest_q  <= dest_d;
    end
  end

endmodule
